// File: rtl/slice_pack_pkg.sv
// Library-wide constants and helpers shared by the CASPER primitives.
package slice_pack_pkg;

   localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
   localparam string ARCH_VIRTEX5    = "VIRTEX5";
   localparam string ARCH_VIRTEX6    = "VIRTEX6";

   function automatic int clog2(input int v);
      int r;
      int p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p * 2;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/slice_pack.sv
// Packs a stream of narrow slices into wide words with valid/ready on both
// sides, early termination via last_in, and output hold under backpressure.
module slice_pack
   import slice_pack_pkg::*;
#(
   parameter string BLOCK_NAME        = "slice_pack",
   parameter int    X                 = 0,
   parameter int    Y                 = 0,
   parameter int    DX                = 0,
   parameter int    DY                = 0,
   parameter string ARCHITECTURE      = "BEHAVIORAL",
   parameter int    INPUT_DATA_WIDTH  = 8,
   parameter int    NUM_SLICES        = 4,
   parameter int    FILL_FROM_MSB     = 1,
   localparam int   OUTPUT_DATA_WIDTH = INPUT_DATA_WIDTH * NUM_SLICES,
   localparam int   CNT_W             = clog2(NUM_SLICES + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [INPUT_DATA_WIDTH-1:0]  data_in,
   input  logic                         valid_in,
   input  logic                         last_in,
   output logic                         ready_out,
   output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
   output logic [CNT_W-1:0]             count_out,
   output logic                         valid_out,
   input  logic                         ready_in
);

   localparam int IW = INPUT_DATA_WIDTH;
   localparam int OW = OUTPUT_DATA_WIDTH;

   if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_beh

      logic [OW-1:0]    acc_q, acc_d;
      logic [OW-1:0]    data_q, data_d;
      logic [OW-1:0]    ins;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] count_q, count_d;
      logic             valid_q, valid_d;
      logic             accept, complete, xfer;

      assign ready_out = !valid_q || ready_in;
      assign accept    = valid_in && ready_out;
      assign xfer      = valid_q && ready_in;
      assign complete  = accept &&
                         (last_in || cnt_q == CNT_W'(NUM_SLICES - 1));

      // Current slice placed in its lane; all other lanes zero.
      always_comb begin
         ins = '0;
         for (int s = 0; s < NUM_SLICES; s++) begin
            if (cnt_q == CNT_W'(s)) begin
               if (FILL_FROM_MSB != 0)
                  ins[OW-(s+1)*IW +: IW] = data_in;
               else
                  ins[s*IW +: IW] = data_in;
            end
         end
      end

      always_comb begin
         acc_d   = acc_q;
         cnt_d   = cnt_q;
         data_d  = data_q;
         count_d = count_q;
         valid_d = valid_q;
         if (complete) begin
            data_d  = acc_q | ins;
            count_d = cnt_q + 1'b1;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
         end else begin
            if (accept) begin
               acc_d = acc_q | ins;
               cnt_d = cnt_q + 1'b1;
            end
            if (xfer)
               valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
         end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
         end
      end

      assign data_out  = data_q;
      assign count_out = count_q;
      assign valid_out = valid_q;

   end else begin : g_unsupported
      $error("slice_pack: unsupported ARCHITECTURE %s", ARCHITECTURE);
   end

endmodule

// File: tb/tb_slice_pack.sv
// Randomised and directed checks of slice_pack against a queue-based model.
module tb_slice_pack;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  data_in = '0;
   logic        valid_in = 1'b0;
   logic        last_in = 1'b0;
   logic        ready_in = 1'b1;

   logic        rdy_m, vld_m, rdy_l, vld_l, rdy_1, vld_1;
   logic [31:0] dat_m, dat_l;
   logic [7:0]  dat_1;
   logic [2:0]  cnt_m, cnt_l;
   logic [0:0]  cnt_1;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model of the MSB-fill instance
   bit          m_valid = 0;
   logic [31:0] m_data  = '0;
   int          m_count = 0;
   int          m_sl[$];
   logic [31:0] exp_words[$];

   always #5 clk = ~clk;

   slice_pack #(.FILL_FROM_MSB(1)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .last_in(last_in), .ready_out(rdy_m), .data_out(dat_m),
      .count_out(cnt_m), .valid_out(vld_m), .ready_in(ready_in));

   slice_pack #(.FILL_FROM_MSB(0)) u_lsb (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .last_in(last_in), .ready_out(rdy_l), .data_out(dat_l),
      .count_out(cnt_l), .valid_out(vld_l), .ready_in(ready_in));

   slice_pack #(.NUM_SLICES(1)) u_one (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .last_in(last_in), .ready_out(rdy_1), .data_out(dat_1),
      .count_out(cnt_1), .valid_out(vld_1), .ready_in(ready_in));

   task automatic model_edge(input bit v, input logic [7:0] d,
                             input bit l, input bit r);
      bit          rdy;
      logic [31:0] w;
      rdy = !m_valid || r;
      if (m_valid && r)
         m_valid = 0;
      if (v && rdy) begin
         m_sl.push_back(int'(d));
         if (l || m_sl.size() == 4) begin
            w = '0;
            foreach (m_sl[k])
               w = w | (32'(m_sl[k]) << (24 - 8 * k));
            m_data  = w;
            m_count = m_sl.size();
            m_valid = 1;
            exp_words.push_back(w);
            m_sl.delete();
         end
      end
   endtask

   task automatic step(input bit v, input logic [7:0] d,
                       input bit l, input bit r);
      valid_in = v;
      data_in  = d;
      last_in  = l;
      ready_in = r;
      #1;
      @(posedge clk);
      model_edge(v, d, l, r);
      #1;
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_data  = '0;
      m_count = 0;
      m_sl.delete();
      exp_words.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      n_vec++;
      if (vld_m !== 1'b0 || dat_m !== 32'h0 || cnt_m !== 3'd0) begin
         n_err++;
         $display("FAIL reset_out got v=%b d=%h c=%0d want 0/0/0",
                  vld_m, dat_m, cnt_m);
      end
      n_vec++;
      if (rdy_m !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready got %b want 1", rdy_m);
      end
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] s [4];
      s = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         step(1, s[i], 0, 1);
         n_vec++;
         if (vld_1 !== 1'b1 || dat_1 !== s[i] || cnt_1 !== 1'b1) begin
            n_err++;
            $display("FAIL n1_word got v=%b d=%h c=%0d want 1/%h/1",
                     vld_1, dat_1, cnt_1, s[i]);
         end
         if (i < 3) begin
            n_vec++;
            if (vld_m !== 1'b0) begin
               n_err++;
               $display("FAIL early_valid got %b want 0 at slice %0d",
                        vld_m, i);
            end
         end
      end
      n_vec++;
      if (vld_m !== 1'b1 || dat_m !== 32'h11223344 || cnt_m !== 3'd4) begin
         n_err++;
         $display("FAIL msb_word got v=%b d=%h c=%0d want 1/11223344/4",
                  vld_m, dat_m, cnt_m);
      end
      n_vec++;
      if (vld_l !== 1'b1 || dat_l !== 32'h44332211 || cnt_l !== 3'd4) begin
         n_err++;
         $display("FAIL lsb_word got v=%b d=%h c=%0d want 1/44332211/4",
                  vld_l, dat_l, cnt_l);
      end
      step(0, 8'h00, 0, 1);
      n_vec++;
      if (vld_m !== 1'b0 || dat_m !== 32'h11223344) begin
         n_err++;
         $display("FAIL after_xfer got v=%b d=%h want 0/11223344",
                  vld_m, dat_m);
      end
   endtask

   task automatic test_partial();
      step(1, 8'hAA, 0, 1);
      step(1, 8'hBB, 1, 1);
      n_vec++;
      if (vld_m !== 1'b1 || dat_m !== 32'hAABB0000 || cnt_m !== 3'd2) begin
         n_err++;
         $display("FAIL partial got v=%b d=%h c=%0d want 1/aabb0000/2",
                  vld_m, dat_m, cnt_m);
      end
      step(1, 8'h01, 0, 1);
      step(0, 8'h00, 1, 1);
      step(1, 8'h02, 0, 1);
      step(1, 8'h03, 0, 1);
      step(1, 8'h04, 1, 1);
      n_vec++;
      if (vld_m !== 1'b1 || dat_m !== 32'h01020304 || cnt_m !== 3'd4) begin
         n_err++;
         $display("FAIL no_stale got v=%b d=%h c=%0d want 1/01020304/4",
                  vld_m, dat_m, cnt_m);
      end
      step(1, 8'h7E, 1, 1);
      n_vec++;
      if (vld_m !== 1'b1 || dat_m !== 32'h7E000000 || cnt_m !== 3'd1) begin
         n_err++;
         $display("FAIL first_last got v=%b d=%h c=%0d want 1/7e000000/1",
                  vld_m, dat_m, cnt_m);
      end
      step(0, 8'h00, 0, 1);
   endtask

   task automatic test_hold();
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      step(1, 8'h44, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 8'h99, 0, 0);
         n_vec++;
         if (vld_m !== 1'b1 || dat_m !== 32'h11223344 || cnt_m !== 3'd4 ||
             rdy_m !== 1'b0) begin
            n_err++;
            $display("FAIL hold got v=%b d=%h c=%0d r=%b want 1/11223344/4/0",
                     vld_m, dat_m, cnt_m, rdy_m);
         end
      end
      valid_in = 1'b1;
      data_in  = 8'hA1;
      ready_in = 1'b1;
      #1;
      n_vec++;
      if (rdy_m !== 1'b1) begin
         n_err++;
         $display("FAIL release_ready got %b want 1", rdy_m);
      end
      step(1, 8'hA1, 0, 1);
      n_vec++;
      if (vld_m !== 1'b0) begin
         n_err++;
         $display("FAIL release_xfer got v=%b want 0", vld_m);
      end
      step(1, 8'hA2, 0, 1);
      step(1, 8'hA3, 0, 1);
      step(1, 8'hA4, 0, 1);
      n_vec++;
      if (vld_m !== 1'b1 || dat_m !== 32'hA1A2A3A4) begin
         n_err++;
         $display("FAIL after_hold got v=%b d=%h want 1/a1a2a3a4",
                  vld_m, dat_m);
      end
      step(0, 8'h00, 0, 1);
   endtask

   task automatic test_mid_reset();
      step(1, 8'hDE, 0, 1);
      step(1, 8'hAD, 0, 1);
      step(1, 8'h01, 1, 0);
      step(0, 8'h00, 0, 0);
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (vld_m !== 1'b0 || dat_m !== 32'h0 || cnt_m !== 3'd0) begin
         n_err++;
         $display("FAIL async_rst got v=%b d=%h c=%0d want 0/0/0",
                  vld_m, dat_m, cnt_m);
      end
      model_reset();
      valid_in = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      step(1, 8'h55, 0, 1);
      step(1, 8'h66, 0, 1);
      step(1, 8'h77, 0, 1);
      n_vec++;
      if (vld_m !== 1'b0) begin
         n_err++;
         $display("FAIL rst_discard got v=%b want 0", vld_m);
      end
      step(1, 8'h88, 0, 1);
      n_vec++;
      if (vld_m !== 1'b1 || dat_m !== 32'h55667788 || cnt_m !== 3'd4) begin
         n_err++;
         $display("FAIL post_rst got v=%b d=%h c=%0d want 1/55667788/4",
                  vld_m, dat_m, cnt_m);
      end
      step(0, 8'h00, 0, 1);
      exp_words.delete();
   endtask

   task automatic test_random();
      int          acc;
      int          got;
      int          cyc;
      bit          v, r;
      logic [7:0]  d;
      logic [31:0] w;
      acc = 0;
      got = 0;
      cyc = 0;
      while ((acc < 32 || m_valid) && cyc < 600) begin
         cyc++;
         v = (acc < 32) && ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         d = 8'($urandom);
         valid_in = v;
         data_in  = d;
         last_in  = 1'b0;
         ready_in = r;
         #1;
         n_vec++;
         if (rdy_m !== (!m_valid || r)) begin
            n_err++;
            $display("FAIL rnd_ready got %b want %b cyc %0d",
                     rdy_m, !m_valid || r, cyc);
         end
         if (m_valid && r) begin
            w = exp_words.size() > 0 ? exp_words.pop_front() : 32'hx;
            got++;
            n_vec++;
            if (vld_m !== 1'b1 || dat_m !== w || cnt_m !== 3'd4) begin
               n_err++;
               $display("FAIL rnd_word got v=%b d=%h c=%0d want 1/%h/4",
                        vld_m, dat_m, cnt_m, w);
            end
         end
         if (v && (!m_valid || r))
            acc++;
         step(v, d, 0, r);
         n_vec++;
         if (vld_m !== m_valid ||
             (m_valid && (dat_m !== m_data || cnt_m !== 3'(m_count)))) begin
            n_err++;
            $display("FAIL rnd_state got v=%b d=%h c=%0d want %b/%h/%0d",
                     vld_m, dat_m, cnt_m, m_valid, m_data, m_count);
         end
      end
      n_vec++;
      if (got !== 8 || acc !== 32) begin
         n_err++;
         $display("FAIL rnd_total got %0d words %0d slices want 8/32",
                  got, acc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_hold();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
